pe_net_endpoint: RTL
====================

// Module: pe_net_endpoint
// PURPOSE
//  Network endpoint for one processing element, attached to the router's local (5th) port.
//  Host-side TX requests are packetized into 20-bit flits and injected under credit flow control.
//  Ejected flits are buffered and presented to the host.
//  It drives the router's in5/vi5 and consumes its o5/vo5/co5; single-flit packets only.
//  Flit format: [19:18] dest_cluster, [17:16] dest_local, [15:0] payload.
// PARAMETERS
//  TX_DEPTH  4   TX FIFO entries, power of 2, >=2
//  RX_DEPTH  4   RX FIFO entries, power of 2, >=2
//  CREDITS   4   initial credit count = router local-input buffer depth
//  CNT_W     16  width of the statistics counters
// PORTS
//  clk        in   1      clock, rising edge
//  rst        in   1      asynchronous active-high reset
//  tx_valid   in   1      host offers a packet
//  tx_ready   out  1      TX FIFO not full; transfer occurs when tx_valid & tx_ready
//  tx_dest    in   4      {dest_cluster, dest_local}
//  tx_data    in   16     payload
//  dataout    out  20     injected flit (to router in5)
//  out_valid  out  1      injected flit valid (to router vi5), one cycle per flit
//  ci         in   1      credit return pulse from router (co5), one credit per cycle high
//  datain     in   20     ejected flit (router o5)
//  in_valid   in   1      ejected flit valid (router vo5); no backpressure exists
//  rx_valid   out  1      RX FIFO not empty
//  rx_ready   in   1      host pops the head when rx_valid & rx_ready
//  rx_data    out  16     head payload, datain[15:0] of the oldest entry
//  read       out  16     payload of the most recently popped flit
//  tx_count   out  CNT_W  flits injected, wraps modulo 2^CNT_W
//  rx_count   out  CNT_W  flits accepted into the RX FIFO, wraps
//  err_ovf    out  1      sticky: ejected flit dropped because the RX FIFO was full
//  err_credit out  1      sticky: ci received while credit count == CREDITS
// BEHAVIOUR
//  Reset values (async, immediate):
//   - FIFOs empty; credit_cnt = CREDITS.
//   - dataout, out_valid, read, tx_count, rx_count, err_ovf, err_credit all 0.
//   - tx_ready = 1, rx_valid = 0.
//  TX FIFO: push on tx_valid & tx_ready. tx_ready = !full (combinational from count; no push/pop bypass).
//  Injection: inj = tx_nonempty & (credit_cnt != 0), evaluated each cycle.
//   - On inj: dataout <= head, out_valid <= 1, pop head.
//   - Otherwise out_valid <= 0; dataout holds its last value.
//   - A pushed flit appears on dataout at the earliest on the edge after the push edge (1-cycle latency).
//   - Back-to-back injection runs at 1 flit/cycle while credits last.
//  Credit counter: next = cnt - inj + ci.
//   - inj & ci in the same cycle: cnt unchanged.
//   - ci with cnt == CREDITS and no inj: cnt stays CREDITS, err_credit <= 1.
//   - cnt never underflows (inj requires cnt != 0).
//  RX FIFO: accept datain when in_valid & (!full | pop_this_cycle).
//   - pop = rx_valid & rx_ready.
//   - in_valid while full with no pop: flit dropped, err_ovf <= 1, rx_count unchanged.
//   - rx_data/rx_valid are combinational from the head; order is strict FIFO.
//   - On pop: read <= head payload.
//  tx_count += inj; rx_count += accept; both wrap silently.
//  Error flags clear only on rst.
//  Reset mid-operation discards all buffered flits and restores full credits; no partial state survives.
// TESTING
//  1. Assert rst mid-run with flits buffered -> next cycle: all outputs at reset values, credit_cnt=4, tx_ready=1.
//  2. Push 6 flits (dest=4'b0110, data=0x0001..0x0006), ci=0.
//     -> flits 0x0001..0x0004 appear on 4 consecutive cycles as 20'h6_0001..6_0004, then out_valid=0.
//     -> Pulse ci once -> 20'h6_0005 next cycle; tx_count=5.
//  3. Run with credit_cnt=1; inj and ci in the same cycle -> credit_cnt stays 1, next flit injects the following cycle.
//  4. ci pulse at credit_cnt=4 with empty TX -> err_credit=1, credit_cnt=4.
//  5. rx_ready=0; eject 5 flits 0x00A1..0x00A5 -> rx_count=4, err_ovf=1.
//     -> Drain: rx_data 0x00A1..0x00A4 in order; read=0x00A4 after the last pop.
//  6. RX full; in_valid and pop in the same cycle -> new flit accepted, rx_count+1, err_ovf unchanged.

Source files
------------

// File: rtl/pe_net_endpoint.sv
// pe_net_endpoint: PE endpoint on the router local port. It packetizes host TX requests into
// 20-bit flits, injects them under credit flow control, and buffers ejected flits for the host.
// Ports: clk, rst (async, active high); tx_valid/tx_ready/tx_dest/tx_data (host TX);
//   dataout/out_valid (to router in5/vi5); ci (credit return, co5);
//   datain/in_valid (from router o5/vo5); rx_valid/rx_ready/rx_data/read (host RX);
//   tx_count/rx_count (statistics); err_ovf/err_credit (sticky error flags).
module pe_net_endpoint #(
  parameter int TX_DEPTH = 4,
  parameter int RX_DEPTH = 4,
  parameter int CREDITS  = 4,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tx_valid,
  output logic             tx_ready,
  input  logic [3:0]       tx_dest,
  input  logic [15:0]      tx_data,
  output logic [19:0]      dataout,
  output logic             out_valid,
  input  logic             ci,
  input  logic [19:0]      datain,
  input  logic             in_valid,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic [15:0]      rx_data,
  output logic [15:0]      read,
  output logic [CNT_W-1:0] tx_count,
  output logic [CNT_W-1:0] rx_count,
  output logic             err_ovf,
  output logic             err_credit
);

  localparam int TAW = $clog2(TX_DEPTH);
  localparam int TCW = TAW + 1;
  localparam int RAW = $clog2(RX_DEPTH);
  localparam int RCW = RAW + 1;
  localparam int CRW = $clog2(CREDITS + 1);
  localparam logic [TCW-1:0] TX_FULL = TCW'(TX_DEPTH);
  localparam logic [RCW-1:0] RX_FULL = RCW'(RX_DEPTH);
  localparam logic [CRW-1:0] CR_MAX  = CRW'(CREDITS);

  // TX path
  logic [19:0]    tx_mem [TX_DEPTH];
  logic [TAW-1:0] tx_wp;
  logic [TAW-1:0] tx_rp;
  logic [TCW-1:0] tx_cnt;
  logic [CRW-1:0] credit_cnt;
  logic           tx_push;
  logic           inj;

  assign tx_ready = (tx_cnt != TX_FULL);
  assign tx_push  = tx_valid & tx_ready;
  assign inj      = (tx_cnt != '0) & (credit_cnt != '0);

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp] <= {tx_dest, tx_data};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_wp     <= '0;
      tx_rp     <= '0;
      tx_cnt    <= '0;
      dataout   <= '0;
      out_valid <= 1'b0;
      tx_count  <= '0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + TAW'(1);
      if (inj) begin
        tx_rp   <= tx_rp + TAW'(1);
        dataout <= tx_mem[tx_rp];
      end
      out_valid <= inj;
      tx_cnt    <= tx_cnt + TCW'(tx_push) - TCW'(inj);
      tx_count  <= tx_count + CNT_W'(inj);
    end
  end

  // Credits: an injection and a returned credit in the same cycle cancel out.
  // A credit arriving while already full is a router protocol error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      credit_cnt <= CR_MAX;
      err_credit <= 1'b0;
    end else if (inj & ~ci) begin
      credit_cnt <= credit_cnt - CRW'(1);
    end else if (~inj & ci) begin
      if (credit_cnt == CR_MAX) err_credit <= 1'b1;
      else credit_cnt <= credit_cnt + CRW'(1);
    end
  end

  // RX path: the router cannot be stalled, so a full FIFO drops the flit
  // unless the host frees a slot in the same cycle.
  logic [15:0]    rx_mem [RX_DEPTH];
  logic [RAW-1:0] rx_wp;
  logic [RAW-1:0] rx_rp;
  logic [RCW-1:0] rx_cnt;
  logic           rx_pop;
  logic           accept;
  logic           unused_dest;

  assign unused_dest = ^datain[19:16];
  assign rx_valid    = (rx_cnt != '0);
  assign rx_data     = rx_mem[rx_rp];
  assign rx_pop      = rx_valid & rx_ready;
  assign accept      = in_valid & ((rx_cnt != RX_FULL) | rx_pop);

  always_ff @(posedge clk) begin
    if (accept) rx_mem[rx_wp] <= datain[15:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_wp    <= '0;
      rx_rp    <= '0;
      rx_cnt   <= '0;
      read     <= '0;
      rx_count <= '0;
      err_ovf  <= 1'b0;
    end else begin
      if (accept) rx_wp <= rx_wp + RAW'(1);
      if (rx_pop) begin
        rx_rp <= rx_rp + RAW'(1);
        read  <= rx_mem[rx_rp];
      end
      if (in_valid & ~accept) err_ovf <= 1'b1;
      rx_cnt   <= rx_cnt + RCW'(accept) - RCW'(rx_pop);
      rx_count <= rx_count + CNT_W'(accept);
    end
  end

endmodule
